// File: rtl/mistral_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// mistral_mac_pipe_if
// Bundle of the operand, control and result signals of mistral_mac_pipe.
//   master : drives ENA, A, B, IN_VALID, LOAD, SUB; receives Y, OUT_VALID,
//            OVERFLOW (the side that feeds the MAC)
//   slave  : the MAC itself
// CLK and ACLR are not part of the bundle; they are plain module ports.
// ---------------------------------------------------------------------------
interface mistral_mac_pipe_if #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 64
);
    logic                 ENA;
    logic [A_WIDTH-1:0]   A;
    logic [B_WIDTH-1:0]   B;
    logic                 IN_VALID;
    logic                 LOAD;
    logic                 SUB;
    logic [ACC_WIDTH-1:0] Y;
    logic                 OUT_VALID;
    logic                 OVERFLOW;

    modport master (
        output ENA, A, B, IN_VALID, LOAD, SUB,
        input  Y, OUT_VALID, OVERFLOW
    );

    modport slave (
        input  ENA, A, B, IN_VALID, LOAD, SUB,
        output Y, OUT_VALID, OVERFLOW
    );
endinterface

// File: rtl/mistral_mac_pipe.sv
// ---------------------------------------------------------------------------
// mistral_mac_pipe
// Three-stage pipelined multiply-accumulate for Mistral DSP mapping:
// registered operands, registered product, then a load/add/subtract
// accumulator with a sticky overflow flag.
//
// Ports:
//   CLK  : clock, rising edge
//   ACLR : asynchronous active-high clear of every register
//   bus  : mistral_mac_pipe_if.slave
//          ENA       clock enable for every stage
//          A, B      operands (signedness from A_SIGNED / B_SIGNED)
//          IN_VALID  A/B/LOAD/SUB carry an operation
//          LOAD      acc := +/-P instead of acc +/- P
//          SUB       subtract the product
//          Y         accumulator
//          OUT_VALID Y was updated by a valid operation on the last enabled edge
//          OVERFLOW  sticky overflow, cleared by a non-overflowing LOAD
//
// Build option: define MISTRAL_MAC_SATURATE_EN to clamp an overflowing
// accumulator to max/min instead of wrapping modulo 2^ACC_WIDTH.
// The interface instance must use the same widths as this module.
// ---------------------------------------------------------------------------
module mistral_mac_pipe #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int A_SIGNED  = 1,
    parameter int B_SIGNED  = 1,
    parameter int ACC_WIDTH = 64
) (
    input  logic               CLK,
    input  logic               ACLR,
    mistral_mac_pipe_if.slave  bus
);
    localparam int PW         = A_WIDTH + B_WIDTH;
    // Two guard bits hold any sum/difference of two ACC_WIDTH values exactly.
    localparam int XW         = ACC_WIDTH + 2;
    localparam bit ACC_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_acc_too_narrow
        $error("mistral_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (A_WIDTH < 2 || A_WIDTH > 27 || B_WIDTH < 2 || B_WIDTH > 27) begin : g_bad_width
        $error("mistral_mac_pipe: operand widths must be 2..27");
    end

    // True result not representable in ACC_WIDTH bits under acc signedness.
    function automatic logic overflows(input logic signed [XW-1:0] r);
        if (ACC_SIGNED)
            return !((r[XW-1:ACC_WIDTH-1] == '0) || (r[XW-1:ACC_WIDTH-1] == '1));
        else
            return (r[XW-1:ACC_WIDTH] != '0);
    endfunction

    // Reduce the exact result to the accumulator: wrap, or clamp when enabled.
    function automatic logic [ACC_WIDTH-1:0] fit_result(input logic signed [XW-1:0] r);
        logic [ACC_WIDTH-1:0] v;
        v = r[ACC_WIDTH-1:0];
`ifdef MISTRAL_MAC_SATURATE_EN
        if (overflows(r)) begin
            if (r[XW-1]) begin
                v = '0;
                if (ACC_SIGNED) v[ACC_WIDTH-1] = 1'b1;
            end else begin
                v = '1;
                if (ACC_SIGNED) v[ACC_WIDTH-1] = 1'b0;
            end
        end
`endif
        return v;
    endfunction

    logic [A_WIDTH-1:0]   a_p1_q;
    logic [B_WIDTH-1:0]   b_p1_q;
    logic                 vld_p1_q, load_p1_q, sub_p1_q;
    logic [PW-1:0]        prod_p2_q;
    logic                 vld_p2_q, load_p2_q, sub_p2_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 vld_p3_q, ovf_q;

    logic [PW-1:0]          a_ext, b_ext, prod_d;
    logic signed [XW-1:0]   acc_x, p_x, base_x, res_x;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic                   ovf_now, ovf_d;

    // Product: the low PW bits of the PW-bit extended operands are the exact
    // product, since it always fits PW bits in the appropriate signedness.
    always_comb begin
        a_ext  = {{B_WIDTH{(A_SIGNED != 0) && a_p1_q[A_WIDTH-1]}}, a_p1_q};
        b_ext  = {{A_WIDTH{(B_SIGNED != 0) && b_p1_q[B_WIDTH-1]}}, b_p1_q};
        prod_d = a_ext * b_ext;
    end

    always_comb begin
        acc_x   = {{2{ACC_SIGNED && acc_q[ACC_WIDTH-1]}}, acc_q};
        p_x     = {{(XW-PW){ACC_SIGNED && prod_p2_q[PW-1]}}, prod_p2_q};
        base_x  = load_p2_q ? '0 : acc_x;
        res_x   = sub_p2_q ? (base_x - p_x) : (base_x + p_x);
        ovf_now = overflows(res_x);
        acc_d   = fit_result(res_x);
        ovf_d   = ovf_now || (ovf_q && !load_p2_q);
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            vld_p1_q  <= 1'b0;
            load_p1_q <= 1'b0;
            sub_p1_q  <= 1'b0;
            prod_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            load_p2_q <= 1'b0;
            sub_p2_q  <= 1'b0;
            acc_q     <= '0;
            vld_p3_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (bus.ENA) begin
            // Stage 1: operand capture
            a_p1_q    <= bus.A;
            b_p1_q    <= bus.B;
            vld_p1_q  <= bus.IN_VALID;
            load_p1_q <= bus.IN_VALID && bus.LOAD;
            sub_p1_q  <= bus.IN_VALID && bus.SUB;
            // Stage 2: product
            prod_p2_q <= prod_d;
            vld_p2_q  <= vld_p1_q;
            load_p2_q <= load_p1_q;
            sub_p2_q  <= sub_p1_q;
            // Stage 3: accumulator
            vld_p3_q  <= vld_p2_q;
            if (vld_p2_q) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.Y         = acc_q;
    assign bus.OUT_VALID = vld_p3_q;
    assign bus.OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_mistral_mac_pipe.sv
module tb_mistral_mac_pipe;
    logic CLK  = 1'b0;
    logic ACLR = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    // d: defaults; s: 9x9 signed into 18; u: 9x9 unsigned into 18
    mistral_mac_pipe_if #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(64)) if_d ();
    mistral_mac_pipe_if #(.A_WIDTH(9),  .B_WIDTH(9),  .ACC_WIDTH(18)) if_s ();
    mistral_mac_pipe_if #(.A_WIDTH(9),  .B_WIDTH(9),  .ACC_WIDTH(18)) if_u ();

    mistral_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .A_SIGNED(1), .B_SIGNED(1), .ACC_WIDTH(64))
        dut_d (.CLK(CLK), .ACLR(ACLR), .bus(if_d));
    mistral_mac_pipe #(.A_WIDTH(9), .B_WIDTH(9), .A_SIGNED(1), .B_SIGNED(1), .ACC_WIDTH(18))
        dut_s (.CLK(CLK), .ACLR(ACLR), .bus(if_s));
    mistral_mac_pipe #(.A_WIDTH(9), .B_WIDTH(9), .A_SIGNED(0), .B_SIGNED(0), .ACC_WIDTH(18))
        dut_u (.CLK(CLK), .ACLR(ACLR), .bus(if_u));

`ifdef MISTRAL_MAC_SATURATE_EN
    localparam logic [17:0] EXP_S3 = 18'd131071;
    localparam logic [17:0] EXP_U2 = 18'd0;
`else
    localparam logic [17:0] EXP_S3 = 18'd195075;   // -67069 in 18 bits
    localparam logic [17:0] EXP_U2 = 18'd262143;
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 ACLR = 1'b1;
        #2;
        checks++;
        if ({if_d.Y, if_s.Y, if_u.Y} !== '0) begin
            errors++; $display("FAIL reset_y: got %0h required 0", {if_d.Y, if_s.Y, if_u.Y});
        end
        checks++;
        if ({if_d.OUT_VALID, if_s.OUT_VALID, if_u.OUT_VALID} !== 3'b000) begin
            errors++; $display("FAIL reset_out_valid: got %b required 000",
                               {if_d.OUT_VALID, if_s.OUT_VALID, if_u.OUT_VALID});
        end
        checks++;
        if ({if_d.OVERFLOW, if_s.OVERFLOW, if_u.OVERFLOW} !== 3'b000) begin
            errors++; $display("FAIL reset_overflow: got %b required 000",
                               {if_d.OVERFLOW, if_s.OVERFLOW, if_u.OVERFLOW});
        end
        @(negedge CLK);
        ACLR = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        if_d.A = 18'd3; if_d.B = 18'h3FFFB; if_d.LOAD = 1'b1; if_d.SUB = 1'b0; if_d.IN_VALID = 1'b1;
        tick();
        if_d.A = 18'd7; if_d.B = 18'd2; if_d.LOAD = 1'b0;
        tick();
        if_d.IN_VALID = 1'b0;
        checks++;
        if (if_d.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b required 0", if_d.OUT_VALID);
        end
        tick();
        checks++;
        if (if_d.Y !== 64'hFFFF_FFFF_FFFF_FFF1 || if_d.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL basic_y1: got %0d valid %b required -15 valid 1",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
        tick();
        checks++;
        if (if_d.Y !== 64'hFFFF_FFFF_FFFF_FFFF || if_d.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL basic_y2: got %0d valid %b required -1 valid 1",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
        checks++;
        if (if_d.OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL basic_overflow: got %b required 0", if_d.OVERFLOW);
        end
        tick();
        checks++;
        if (if_d.OUT_VALID !== 1'b0 || if_d.Y !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL basic_idle: got %0d valid %b required -1 valid 0",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
    endtask

    task automatic test_signed_overflow();
        logic [17:0] exp_y [5];
        logic        exp_o [5];
        exp_y[0] = 18'd65025;  exp_o[0] = 1'b0;
        exp_y[1] = 18'd130050; exp_o[1] = 1'b0;
        exp_y[2] = EXP_S3;     exp_o[2] = 1'b1;
        exp_y[3] = EXP_S3;     exp_o[3] = 1'b1;   // adding 0 keeps the flag sticky
        exp_y[4] = 18'd1;      exp_o[4] = 1'b0;
        if_s.IN_VALID = 1'b1; if_s.SUB = 1'b0;
        if_s.A = 9'd255; if_s.B = 9'd255; if_s.LOAD = 1'b1;
        tick();
        if_s.LOAD = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin if_s.A = 9'd255; if_s.B = 9'd255; if_s.LOAD = 1'b0; end
                1:       begin if_s.A = 9'd0;   if_s.B = 9'd0;   if_s.LOAD = 1'b0; end
                2:       begin if_s.A = 9'd1;   if_s.B = 9'd1;   if_s.LOAD = 1'b1; end
                default: if_s.IN_VALID = 1'b0;
            endcase
            tick();
            checks++;
            if (if_s.Y !== exp_y[i] || if_s.OVERFLOW !== exp_o[i] || if_s.OUT_VALID !== 1'b1) begin
                errors++; $display("FAIL signed_op%0d: got y=%0d ovf=%b valid=%b required y=%0d ovf=%b valid=1",
                                   i, $signed(if_s.Y), if_s.OVERFLOW, if_s.OUT_VALID,
                                   $signed(exp_y[i]), exp_o[i]);
            end
        end
        tick();
        if_s.LOAD = 1'b0;
    endtask

    task automatic test_unsigned_sub();
        if_u.IN_VALID = 1'b1;
        if_u.A = 9'd2; if_u.B = 9'd3; if_u.LOAD = 1'b1; if_u.SUB = 1'b0;
        tick();
        if_u.A = 9'd1; if_u.B = 9'd7; if_u.LOAD = 1'b0; if_u.SUB = 1'b1;
        tick();
        if_u.A = 9'd0; if_u.B = 9'd0; if_u.LOAD = 1'b1; if_u.SUB = 1'b1;
        tick();
        if_u.IN_VALID = 1'b0; if_u.LOAD = 1'b0; if_u.SUB = 1'b0;
        checks++;
        if (if_u.Y !== 18'd6 || if_u.OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL unsigned_load: got y=%0d ovf=%b required y=6 ovf=0", if_u.Y, if_u.OVERFLOW);
        end
        tick();
        checks++;
        if (if_u.Y !== EXP_U2 || if_u.OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL unsigned_sub: got y=%0d ovf=%b required y=%0d ovf=1",
                               if_u.Y, if_u.OVERFLOW, EXP_U2);
        end
        tick();
        checks++;
        if (if_u.Y !== 18'd0 || if_u.OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL unsigned_clear: got y=%0d ovf=%b required y=0 ovf=0", if_u.Y, if_u.OVERFLOW);
        end
    endtask

    task automatic test_stall();
        if_d.A = 18'd10; if_d.B = 18'd10; if_d.LOAD = 1'b1; if_d.SUB = 1'b0; if_d.IN_VALID = 1'b1;
        tick();
        if_d.IN_VALID = 1'b0; if_d.LOAD = 1'b0; if_d.ENA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if_d.Y !== 64'hFFFF_FFFF_FFFF_FFFF || if_d.OUT_VALID !== 1'b0 || if_d.OVERFLOW !== 1'b0) begin
                errors++; $display("FAIL stall_frozen%0d: got y=%0d valid=%b ovf=%b required y=-1 valid=0 ovf=0",
                                   i, $signed(if_d.Y), if_d.OUT_VALID, if_d.OVERFLOW);
            end
        end
        if_d.ENA = 1'b1;
        tick();
        checks++;
        if (if_d.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL stall_second_edge: got valid=%b required 0", if_d.OUT_VALID);
        end
        tick();
        checks++;
        if (if_d.Y !== 64'd100 || if_d.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL stall_result: got y=%0d valid=%b required y=100 valid=1",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
        if_d.ENA = 1'b0;
        tick();
        tick();
        checks++;
        if (if_d.Y !== 64'd100 || if_d.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL stall_hold_valid: got y=%0d valid=%b required y=100 valid=1",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
        if_d.ENA = 1'b1;
        tick();
        checks++;
        if (if_d.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL stall_release: got valid=%b required 0", if_d.OUT_VALID);
        end
    endtask

    task automatic test_aclr();
        if_u.A = 9'd1; if_u.B = 9'd1; if_u.SUB = 1'b1; if_u.LOAD = 1'b0; if_u.IN_VALID = 1'b1;
        tick();
        if_u.IN_VALID = 1'b0; if_u.SUB = 1'b0;
        tick();
        tick();
        checks++;
        if (if_u.OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL aclr_setup_ovf: got %b required 1", if_u.OVERFLOW);
        end
        if_d.A = 18'd4; if_d.B = 18'd4; if_d.LOAD = 1'b1; if_d.IN_VALID = 1'b1;
        tick();
        if_d.A = 18'd1; if_d.B = 18'd1; if_d.LOAD = 1'b0;
        tick();
        if_d.IN_VALID = 1'b0;
        #2 ACLR = 1'b1;
        #1;
        checks++;
        if (if_d.Y !== 64'd0 || if_d.OUT_VALID !== 1'b0 || if_u.OVERFLOW !== 1'b0 || if_u.Y !== 18'd0) begin
            errors++; $display("FAIL aclr_immediate: got y=%0d valid=%b u_ovf=%b u_y=%0d required all 0",
                               $signed(if_d.Y), if_d.OUT_VALID, if_u.OVERFLOW, if_u.Y);
        end
        tick();
        checks++;
        if (if_d.Y !== 64'd0 || if_d.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL aclr_held: got y=%0d valid=%b required y=0 valid=0",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
        @(negedge CLK);
        ACLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_d.OUT_VALID !== 1'b0 || if_d.Y !== 64'd0) begin
                errors++; $display("FAIL aclr_no_pulse%0d: got y=%0d valid=%b required y=0 valid=0",
                                   i, $signed(if_d.Y), if_d.OUT_VALID);
            end
        end
    endtask

    task automatic test_invalid();
        // After reset, an operation without LOAD adds to a zero accumulator.
        if_d.A = 18'd5; if_d.B = 18'd5; if_d.LOAD = 1'b0; if_d.SUB = 1'b0; if_d.IN_VALID = 1'b1;
        tick();
        if_d.IN_VALID = 1'b0;
        tick();
        tick();
        checks++;
        if (if_d.Y !== 64'd25 || if_d.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL invalid_setup: got y=%0d valid=%b required y=25 valid=1",
                               $signed(if_d.Y), if_d.OUT_VALID);
        end
        if_d.LOAD = 1'b1; if_d.SUB = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_d.A = 18'($urandom);
            if_d.B = 18'($urandom);
            tick();
            checks++;
            if (if_d.Y !== 64'd25 || if_d.OUT_VALID !== 1'b0) begin
                errors++; $display("FAIL invalid_hold%0d: got y=%0d valid=%b required y=25 valid=0",
                                   i, $signed(if_d.Y), if_d.OUT_VALID);
            end
        end
        if_d.LOAD = 1'b0; if_d.SUB = 1'b0;
    endtask

    initial begin
        if_d.ENA = 1'b1; if_d.A = '0; if_d.B = '0; if_d.IN_VALID = 1'b0; if_d.LOAD = 1'b0; if_d.SUB = 1'b0;
        if_s.ENA = 1'b1; if_s.A = '0; if_s.B = '0; if_s.IN_VALID = 1'b0; if_s.LOAD = 1'b0; if_s.SUB = 1'b0;
        if_u.ENA = 1'b1; if_u.A = '0; if_u.B = '0; if_u.IN_VALID = 1'b0; if_u.LOAD = 1'b0; if_u.SUB = 1'b0;
        test_reset();
        test_basic();
        test_signed_overflow();
        test_unsigned_sub();
        test_stall();
        test_aclr();
        test_invalid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
